// File: rtl/kv_mem_pkg.sv
// Shared types for the line-read path: FSM state, requester id and the
// memory line shape used by the arbiter, the memory and the caches.
package kv_mem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_SIZE  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef logic req_id_t;

  typedef logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_t;

endpackage

// File: rtl/kv_rr_arb2.sv
// Two-way round-robin pick: a lone valid always wins, and on a tie the
// requester that did not win last time gets the grant.
module kv_rr_arb2
  import kv_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | last);
  assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/kv_mem_read_arbiter.sv
// Shares the single line-read memory port between instruction-fetch refill
// (requester 0) and data-load refill (requester 1), one line at a time.
module kv_mem_read_arbiter
  import kv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = kv_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = kv_mem_pkg::ADDR_WIDTH,
  parameter int LINE_SIZE  = kv_mem_pkg::LINE_SIZE
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [ADDR_WIDTH-1:0]                i_req0_addr,
  input  logic                                 i_req0_valid,
  output logic                                 o_req0_ready,
  output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_req0_data,
  output logic                                 o_req0_valid,
  input  logic                                 i_req0_ready,
  input  logic [ADDR_WIDTH-1:0]                i_req1_addr,
  input  logic                                 i_req1_valid,
  output logic                                 o_req1_ready,
  output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_req1_data,
  output logic                                 o_req1_valid,
  input  logic                                 i_req1_ready,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic                                 o_mem_valid,
  input  logic                                 i_mem_ready,
  input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] i_mem_data,
  input  logic                                 i_mem_valid,
  output logic                                 o_mem_ready,
  output logic                                 o_busy,
  output logic                                 o_owner
);

  localparam int OFFSET_BITS = $clog2(LINE_SIZE * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  state_t                               state, state_nxt;
  req_id_t                              r_last;
  req_id_t                              r_owner;
  logic [ADDR_WIDTH-1:0]                r_addr;
  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] r_data0, r_data1;
  logic [1:0]                           grant;
  logic                                 accept;
  logic                                 owner_ready;
  logic [ADDR_WIDTH-1:0]                win_addr;

  kv_rr_arb2 u_arb (
    .valid ({i_req1_valid, i_req0_valid}),
    .last  (r_last),
    .grant (grant)
  );

  // Ready is only offered while idle, so at most one line is ever in flight.
  assign o_req0_ready = (state == IDLE) & grant[0];
  assign o_req1_ready = (state == IDLE) & grant[1];
  assign accept       = o_req0_ready | o_req1_ready;
  assign win_addr     = grant[1] ? i_req1_addr : i_req0_addr;
  assign owner_ready  = r_owner ? i_req1_ready : i_req0_ready;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)      state_nxt = ADDR;
      ADDR: if (i_mem_ready) state_nxt = DATA;
      DATA: if (i_mem_valid) state_nxt = RESP;
      RESP: if (owner_ready) state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // r_last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_addr  <= '0;
    end else if (accept) begin
      r_last  <= grant[1];
      r_owner <= grant[1];
      r_addr  <= win_addr & ~OFFSET_MASK;
    end
  end

  // NOTE: the response lines are flops, not a RAM, so clearing them on reset
  // is cheap and makes the held-data outputs well defined from power-up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else if (state == DATA && i_mem_valid) begin
      if (r_owner) r_data1 <= i_mem_data;
      else         r_data0 <= i_mem_data;
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_mem_valid  = (state == ADDR);
  assign o_mem_ready  = (state == DATA);
  assign o_busy       = (state != IDLE);
  assign o_owner      = r_owner;
  assign o_req0_valid = (state == RESP) & ~r_owner;
  assign o_req1_valid = (state == RESP) &  r_owner;
  assign o_req0_data  = r_data0;
  assign o_req1_data  = r_data1;

endmodule

// File: tb/tb_kv_mem_read_arbiter.sv
// Directed and randomized checks of the two-port line-read arbiter against a
// transaction-level model of grants, aligned addresses, latency and held lines.
module tb_kv_mem_read_arbiter;
  import kv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req0_addr, req1_addr;
  logic        req0_valid, req1_valid, req0_ready_in, req1_ready_in;
  logic        o_req0_ready, o_req1_ready, o_req0_valid, o_req1_valid;
  line_t       o_req0_data, o_req1_data;
  logic [31:0] o_mem_addr;
  logic        o_mem_valid, o_mem_ready, o_busy, o_owner;
  logic        mem_ready, mem_valid;
  line_t       mem_data;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state: who won last, and the line each requester holds.
  bit    m_last;
  line_t m_data [2];

  kv_mem_read_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_addr  (req0_addr),
    .i_req0_valid (req0_valid),
    .o_req0_ready (o_req0_ready),
    .o_req0_data  (o_req0_data),
    .o_req0_valid (o_req0_valid),
    .i_req0_ready (req0_ready_in),
    .i_req1_addr  (req1_addr),
    .i_req1_valid (req1_valid),
    .o_req1_ready (o_req1_ready),
    .o_req1_data  (o_req1_data),
    .o_req1_valid (o_req1_valid),
    .i_req1_ready (req1_ready_in),
    .o_mem_addr   (o_mem_addr),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (mem_ready),
    .i_mem_data   (mem_data),
    .i_mem_valid  (mem_valid),
    .o_mem_ready  (o_mem_ready),
    .o_busy       (o_busy),
    .o_owner      (o_owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LINE_SIZE; k++) l[k] = $urandom;
    return l;
  endfunction

  task automatic chk_held_data(input string tag);
    chk({tag, "_data0"}, o_req0_data, m_data[0]);
    chk({tag, "_data1"}, o_req1_data, m_data[1]);
  endtask

  // Runs one full transaction starting at a negedge with the DUT idle and
  // returns at the negedge right after the response handshake. The losing
  // requester (on a tie) keeps its valid asserted throughout.
  task automatic run_txn(input bit v0, input bit v1, input logic [31:0] a0,
                         input logic [31:0] a1, input line_t line,
                         input int as, input int ds, input int rs);
    int          w;
    int          t_acc;
    logic [31:0] exp_addr;
    w        = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
    exp_addr = (w == 1 ? a1 : a0) & 32'hFFFF_FFF0;  // 4 x 32-bit words = 16-byte lines
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    #1;
    chk("idle_busy", o_busy, 1'b0);
    chk("grant0", o_req0_ready, w == 0);
    chk("grant1", o_req1_ready, w == 1);
    t_acc  = cyc;
    m_last = (w == 1);
    @(posedge clk); @(negedge clk);
    if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;

    for (int i = 0; i <= as; i++) begin
      mem_ready = (i == as);
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = rand_line();
      #1;
      chk("addr_valid", o_mem_valid, 1'b1);
      chk("addr_value", o_mem_addr, exp_addr);
      chk("addr_owner", o_owner, w[0]);
      chk("addr_rdy", {o_req0_ready, o_req1_ready, o_mem_ready}, 3'b000);
      chk("addr_rsp", {o_req0_valid, o_req1_valid}, 2'b00);
      @(posedge clk); @(negedge clk);
    end

    for (int i = 0; i <= ds; i++) begin
      mem_valid = (i == ds);
      mem_data  = (i == ds) ? line : rand_line();
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("data_memrdy", {o_mem_ready, o_mem_valid}, 2'b10);
      chk("data_rdy", {o_req0_ready, o_req1_ready}, 2'b00);
      chk("data_rsp", {o_req0_valid, o_req1_valid}, 2'b00);
      @(posedge clk); @(negedge clk);
    end
    mem_valid = 1'b0;
    mem_ready = 1'b0;
    m_data[w] = line;

    for (int i = 0; i <= rs; i++) begin
      if (w == 0) begin req0_ready_in = (i == rs); req1_ready_in = 1'b1; end
      else        begin req1_ready_in = (i == rs); req0_ready_in = 1'b1; end
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = rand_line();
      #1;
      if (i == 0) chk("latency", 32'(cyc - t_acc), 32'(3 + as + ds));
      chk("resp_valid0", o_req0_valid, w == 0);
      chk("resp_valid1", o_req1_valid, w == 1);
      chk_held_data("resp");
      chk("resp_rdy", {o_req0_ready, o_req1_ready}, 2'b00);
      chk("resp_mem", {o_mem_valid, o_mem_ready}, 2'b00);
      @(posedge clk); @(negedge clk);
    end
    req0_ready_in = 1'b0;
    req1_ready_in = 1'b0;
    mem_valid     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    line_t l;
    rst = 1'b1;
    req0_addr = '0; req1_addr = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ready_in = 1'b0; req1_ready_in = 1'b0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_data = '0;
    m_last = 1'b1;
    m_data[0] = '0; m_data[1] = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valids", {o_req0_valid, o_req1_valid, o_mem_valid, o_mem_ready}, 4'b0000);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_owner", o_owner, 1'b0);
    chk_held_data("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single req0, zero-wait memory.
    l = {32'hA, 32'hB, 32'hC, 32'hD};
    run_txn(1'b1, 1'b0, 32'h0000_1234, 32'h0, l, 0, 0, 0);

    // Round-robin: a lone req1 first, then ties held across transactions.
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_2008, rand_line(), 0, 0, 0);
    run_txn(1'b1, 1'b1, 32'h0000_3001, 32'h0000_4002, rand_line(), 0, 0, 0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_4002, rand_line(), 0, 0, 0);
    run_txn(1'b1, 1'b1, 32'h0000_5005, 32'h0000_6006, rand_line(), 0, 0, 0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_6006, rand_line(), 0, 0, 0);

    // Memory stalls: address held 5 cycles, line held back 3 cycles.
    run_txn(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, rand_line(), 5, 3, 0);

    // Requester 1 backpressures 4 cycles while req0 waits, then req0 goes next.
    run_txn(1'b1, 1'b1, 32'h0000_7777, 32'h0000_8888, rand_line(), 0, 0, 4);
    run_txn(1'b1, 1'b0, 32'h0000_7777, 32'h0, rand_line(), 1, 1, 0);
    idle_cycles(1);

    // Spurious memory handshakes while idle are ignored.
    mem_valid = 1'b1;
    mem_ready = 1'b1;
    mem_data  = {4{32'hFFFF_FFFF}};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("spur_busy", o_busy, 1'b0);
      chk("spur_out", {o_req0_valid, o_req1_valid, o_mem_valid, o_mem_ready}, 4'b0000);
      chk_held_data("spur");
      @(posedge clk); @(negedge clk);
    end
    mem_valid = 1'b0;
    mem_ready = 1'b0;

    // Reset while a line is being awaited.
    req0_valid = 1'b1; req0_addr = 32'h0000_9999;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    mem_ready  = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_data", o_mem_ready, 1'b1);
    rst = 1'b1;
    #1;
    m_last = 1'b1;
    m_data[0] = '0; m_data[1] = '0;
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_out", {o_req0_valid, o_req1_valid, o_mem_valid, o_mem_ready}, 4'b0000);
    chk("mid_rst_addr", o_mem_addr, 32'h0);
    chk("mid_rst_owner", o_owner, 1'b0);
    chk_held_data("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 1'b1, 32'h0000_A0A4, 32'h0000_B0B8, rand_line(), 0, 1, 0);

    // Randomized traffic with random stalls and backpressure.
    for (int t = 0; t < 30; t++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      run_txn(v[0], v[1], $urandom, $urandom, rand_line(),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
